// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM (fetch/decode/execute/memory/writeback).
//   clk, reset (async, active-high) ; opcode = IR[31:26], sampled in DECODE only ;
//   mem_ready = memory completes this cycle ; datapath strobes/selects out ;
//   state = current state ; illegal / mem_timeout = sticky traps ; instret = retired count.
module mc_control #(
    parameter int   CNT_W       = 32,
    parameter logic ENABLE_JUMP = 1'b1,
    parameter int   WAIT_LIMIT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic             Ne,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOP,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instret
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDI_EX = 4'd9;
    localparam logic [3:0] S_ADDI_WB = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd12;
    localparam logic [7:0] WAIT_LIM  = 8'(WAIT_LIMIT);

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             waiting, timed_out, retire;

    always_comb begin
        waiting   = state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR;
        // mem_ready in the limit cycle still completes the access
        timed_out = WAIT_LIM != 8'd0 && !mem_ready && wait_q + 8'd1 == WAIT_LIM;
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : timed_out ? S_TRAP : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXEC;
                    6'b000100, 6'b000101: state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDI_EX;
                    6'b000010: begin
                        state_d   = ENABLE_JUMP ? S_JUMP : S_TRAP;
                        illegal_d = illegal_q | ~ENABLE_JUMP;
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = op_q == 6'b101011 ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : timed_out ? S_TRAP : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : timed_out ? S_TRAP : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_TRAP;
        endcase
        timeout_d = timeout_q | (waiting & timed_out);
        // counter restarts whenever a new state is entered
        wait_d    = state_d != state_q ? 8'd0 : waiting ? wait_q + 8'd1 : wait_q;
        // FETCH is only re-entered from the last cycle of an instruction
        retire    = state_d == S_FETCH && state_q != S_FETCH;
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
         RegWrite, RegDst, ALUSrcA, Ne, PCSource, ALUSrcB, AluOP} = '0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                AluOP   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                AluOP       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Ne          = op_q[0];
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
        // architectural writes are suppressed for as long as reset is held
        PCWrite     = PCWrite & ~reset;
        IRWrite     = IRWrite & ~reset;
        RegWrite    = RegWrite & ~reset;
        MemWrite    = MemWrite & ~reset;
        PCWriteCond = PCWriteCond & ~reset;
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign instret     = instret_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: three mc_control instances (default, WAIT_LIMIT=4, ENABLE_JUMP=0) checked against a sequence-table model.
module tb_mc_control;
    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [5:0] opcode;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    logic [16:0] got [3];
    logic [3:0]  st  [3];
    logic        ill [3];
    logic        tmo [3];
    logic [31:0] ret [3];

    for (genvar g = 0; g < 3; g++) begin : u
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, ne;
        logic [1:0] pcs, asb, aop;
        mc_control #(.CNT_W(32), .ENABLE_JUMP(g != 2), .WAIT_LIMIT(g == 1 ? 4 : 15)) dut (
            .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
            .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
            .MemtoReg(m2r), .IRWrite(irw), .RegWrite(rw), .RegDst(rd), .ALUSrcA(asa), .Ne(ne),
            .PCSource(pcs), .ALUSrcB(asb), .AluOP(aop),
            .state(st[g]), .illegal(ill[g]), .mem_timeout(tmo[g]), .instret(ret[g]));
        assign got[g] = {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, ne, pcs, asb, aop};
    end

    // Model: each instruction is a fixed list of states after DECODE; finishing the list retires it.
    typedef struct packed {
        logic [3:0]      st;
        logic [5:0]      op;
        logic [7:0]      wt;
        logic            ill;
        logic            to;
        logic [31:0]     ret;
        logic [2:0][3:0] seq;
        logic [1:0]      n;
        logic [1:0]      p;
    } mst_t;
    mst_t m [3];

    function automatic mst_t nxt(mst_t c, logic [5:0] opc, logic mr, int i);
        mst_t x;
        logic go;
        int lim;
        x = c;
        go = 1'b0;
        lim = (i == 1) ? 4 : 15;
        if (c.st == 4'd0 || c.st == 4'd3 || c.st == 4'd5) begin
            if (mr) go = 1'b1;
            else if (lim != 0 && int'(c.wt) + 1 == lim) begin
                x.st = 4'd12;
                x.to = 1'b1;
            end else x.wt = c.wt + 8'd1;
        end else if (c.st == 4'd1) begin
            x.op = opc;
            x.p = 2'd1;
            x.n = 2'd0;
            if (opc == 6'b100011) begin x.seq = {4'd4, 4'd3, 4'd2}; x.n = 2'd3; end
            else if (opc == 6'b101011) begin x.seq = {4'd0, 4'd5, 4'd2}; x.n = 2'd2; end
            else if (opc == 6'b000000) begin x.seq = {4'd0, 4'd7, 4'd6}; x.n = 2'd2; end
            else if (opc == 6'b000100 || opc == 6'b000101) begin x.seq = {4'd0, 4'd0, 4'd8}; x.n = 2'd1; end
            else if (opc == 6'b001000) begin x.seq = {4'd0, 4'd10, 4'd9}; x.n = 2'd2; end
            else if (opc == 6'b000010 && i != 2) begin x.seq = {4'd0, 4'd0, 4'd11}; x.n = 2'd1; end
            if (x.n == 2'd0) begin
                x.st = 4'd12;
                x.ill = 1'b1;
            end else x.st = x.seq[0];
        end else if (c.st != 4'd12) go = 1'b1;
        if (go) begin
            if (c.st == 4'd0) x.st = 4'd1;
            else if (c.p < c.n) begin
                x.st = c.seq[c.p];
                x.p = c.p + 2'd1;
            end else begin
                x.st = 4'd0;
                x.ret = c.ret + 32'd1;
            end
        end
        if (x.st != c.st) x.wt = 8'd0;
        return x;
    endfunction

    function automatic logic [16:0] exp_out(mst_t c, logic mr, logic rst);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, ne;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, ne, pcs, asb, aop} = '0;
        case (c.st)
            4'd0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1: asb = 2'b11;
            4'd2: begin asa = 1'b1; asb = 2'b10; end
            4'd3: begin mrd = 1'b1; iord = 1'b1; end
            4'd4: begin m2r = 1'b1; rw = 1'b1; end
            4'd5: begin mwr = 1'b1; iord = 1'b1; end
            4'd6: begin asa = 1'b1; aop = 2'b10; end
            4'd7: begin rd = 1'b1; rw = 1'b1; end
            4'd8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; ne = c.op[0]; end
            4'd9: begin asa = 1'b1; asb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin pcw = 1'b1; pcs = 2'b10; end
            default: ;
        endcase
        if (rst) {pcw, irw, rw, mwr, pcwc} = '0;
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, ne, pcs, asb, aop};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) m[i] <= reset ? '0 : nxt(m[i], opcode, mem_ready, i);
    end

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g === e) passes++;
        else $display("FAIL %s got %0h expected %0h at %0t", nm, g, e, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("outputs[%0d]", i), 32'(got[i]), 32'(exp_out(m[i], mem_ready, reset)));
            chk($sformatf("state[%0d]", i), 32'(st[i]), 32'(m[i].st));
            chk($sformatf("illegal[%0d]", i), 32'(ill[i]), 32'(m[i].ill));
            chk($sformatf("mem_timeout[%0d]", i), 32'(tmo[i]), 32'(m[i].to));
            chk($sformatf("instret[%0d]", i), ret[i], m[i].ret);
        end
    end

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    int lw_states [5] = '{1, 2, 3, 4, 0};

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b0;
        step(2);
        chk("rst_state", 32'(st[0]), 32'd0);
        chk("rst_memread", 32'(got[0][13]), 32'd1);
        chk("rst_alusrcb", 32'(got[0][3:2]), 32'd1);
        chk("rst_irwrite_gated", 32'(got[0][10]), 32'd0);
        chk("rst_pcwrite_gated", 32'(got[0][16]), 32'd0);
        reset = 1'b0;
        opcode = 6'b100011;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("lw_state", 32'(st[0]), 32'(lw_states[k]));
            if (k == 3) begin
                chk("lw_memtoreg", 32'(got[0][11]), 32'd1);
                chk("lw_regwrite", 32'(got[0][9]), 32'd1);
            end
        end
        chk("lw_instret", ret[0], 32'd1);

        do_reset();
        opcode = 6'b000100;
        step(2);
        chk("beq_state", 32'(st[0]), 32'd8);
        chk("beq_ne", 32'(got[0][6]), 32'd0);
        chk("beq_pcwritecond", 32'(got[0][15]), 32'd1);
        chk("beq_pcsource", 32'(got[0][5:4]), 32'd1);
        opcode = 6'b000101;
        step(3);
        chk("bne_state", 32'(st[0]), 32'd8);
        chk("bne_ne", 32'(got[0][6]), 32'd1);
        step(1);
        chk("branch_instret", ret[0], 32'd2);

        do_reset();
        opcode = 6'b101011;
        step(2);
        mem_ready = 1'b0;
        opcode = 6'b111111;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("sw_state", 32'(st[0]), 32'd5);
            chk("sw_memwrite", 32'(got[0][12]), 32'd1);
            chk("sw_iord", 32'(got[0][14]), 32'd1);
        end
        mem_ready = 1'b1;
        step(1);
        chk("sw_done_state", 32'(st[0]), 32'd0);
        chk("sw_instret", ret[0], 32'd1);
        chk("sw_limit_ready_wins", 32'(tmo[1]), 32'd0);

        mem_ready = 1'b0;
        opcode = 6'b000000;
        do_reset();
        step(3);
        chk("fetch_wait_state", 32'(st[1]), 32'd0);
        step(1);
        chk("timeout_state", 32'(st[1]), 32'd12);
        chk("timeout_flag", 32'(tmo[1]), 32'd1);
        chk("no_timeout_default", 32'(tmo[0]), 32'd0);
        mem_ready = 1'b1;
        step(2);
        chk("trap_held", 32'(st[1]), 32'd12);
        chk("trap_strobes", 32'(got[1]), 32'd0);

        do_reset();
        opcode = 6'b111111;
        step(2);
        chk("illegal_state", 32'(st[0]), 32'd12);
        chk("illegal_flag", 32'(ill[0]), 32'd1);
        do_reset();
        chk("illegal_cleared", 32'(ill[0]), 32'd0);
        opcode = 6'b000010;
        step(2);
        chk("j_state", 32'(st[0]), 32'd11);
        chk("j_pcwrite", 32'(got[0][16]), 32'd1);
        chk("j_pcsource", 32'(got[0][5:4]), 32'd2);
        chk("j_disabled_state", 32'(st[2]), 32'd12);
        chk("j_disabled_illegal", 32'(ill[2]), 32'd1);
        step(1);
        chk("j_instret", ret[0], 32'd1);

        do_reset();
        opcode = 6'b000000;
        step(4);
        chk("r_instret", ret[0], 32'd1);
        opcode = 6'b001000;
        step(4);
        chk("addi_instret", ret[0], 32'd2);
        opcode = 6'b100011;
        step(3);
        mem_ready = 1'b0;
        opcode = 6'b000101;
        step(6);
        chk("memrd_timeout_state", 32'(st[1]), 32'd12);
        mem_ready = 1'b1;
        step(2);
        chk("lw_wait_instret", ret[0], 32'd3);

        do_reset();
        opcode = 6'b000000;
        step(2);
        chk("exec_state", 32'(st[0]), 32'd6);
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(st[0]), 32'd0);
        chk("async_reset_instret", ret[0], 32'd0);
        chk("async_reset_regwrite", 32'(got[0][9]), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("after_reset_state", 32'(st[0]), 32'd1);
        step(1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
